// File: rtl/sprite_sched_pkg.sv
// sprite_sched_pkg: descriptor field layout, FSM encoding and default sprite size for sprite_scheduler.
package sprite_sched_pkg;
    localparam int ENABLE_BIT = 28;
    localparam int X_MSB      = 27;
    localparam int X_LSB      = 18;
    localparam int Y_MSB      = 17;
    localparam int Y_LSB      = 9;
    localparam int OFFSET_MSB = 8;
    localparam int OFFSET_LSB = 0;
    localparam int SIZE_LINE  = 20;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAW = 2'd2} state_e;
endpackage

// File: rtl/sprite_window_cmp.sv
// sprite_window_cmp: flags coord inside [origin, origin+SIZE-1], evaluated one bit wider so windows near the top of the range do not wrap.
module sprite_window_cmp #(
    parameter int W    = 10,
    parameter int SIZE = 20
) (
    input  logic [W-1:0] coord_i,
    input  logic [W-1:0] origin_i,
    output logic         in_o
);
    logic [W:0] lo;
    logic [W:0] hi;
    assign lo   = {1'b0, origin_i};
    assign hi   = lo + (W+1)'(SIZE - 1);
    assign in_o = ({1'b0, coord_i} >= lo) && ({1'b0, coord_i} <= hi);
endmodule

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: double-buffered sprite descriptor bank, per-line scan into a short list, per-pixel priority select.
// Define SPRITE_OVERFLOW_EN to get the sticky per-frame overflow flag; otherwise overflow stays 0.
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SPRITES  = 8,
    parameter int MAX_PER_LINE = 4,
    parameter int size_x       = 10,
    parameter int size_y       = 9,
    parameter int size_line    = SIZE_LINE
) (
    input  logic                           clk_pixel,
    input  logic                           reset,
    input  logic [size_x-1:0]              pixel_x,
    input  logic [size_y-1:0]              pixel_y,
    input  logic                           line_start,
    input  logic                           frame_start,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0] wr_addr,
    input  logic [31:0]                    wr_data,
    input  logic                           count_finished,
    output logic                           sprite_on,
    output logic [31:0]                    sprite_datas,
    output logic                           line_ready,
    output logic                           overflow
);
    localparam int AW = $clog2(NUM_SPRITES);
    localparam int LW = $clog2(MAX_PER_LINE);
    localparam int CW = $clog2(MAX_PER_LINE + 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [size_y-1:0] line_y_q, line_y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       shadow_q [NUM_SPRITES];
    logic [31:0]       active_q [NUM_SPRITES];
    logic [31:0]       list_q [MAX_PER_LINE];
    logic [31:0]       list_d [MAX_PER_LINE];
    logic              on_q, on_d, ready_q, ready_d, ovf_q, ovf_d;
    logic [31:0]       datas_q, datas_d;
    logic [7:0]        done_cnt_q, done_cnt_d;
    logic              unused_done;
    logic              y_in, y_hit;
    logic [MAX_PER_LINE-1:0] x_hit;
    logic              win_valid;
    logic [LW-1:0]     win_idx;

    sprite_window_cmp #(.W(size_y), .SIZE(size_line)) u_ycmp (
        .coord_i (line_y_q),
        .origin_i(active_q[idx_q][Y_MSB:Y_LSB]),
        .in_o    (y_in)
    );
    assign y_hit = y_in && active_q[idx_q][ENABLE_BIT];

    for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_xcmp
        sprite_window_cmp #(.W(size_x), .SIZE(size_line)) u_xcmp (
            .coord_i (pixel_x),
            .origin_i(list_q[g][X_MSB:X_LSB]),
            .in_o    (x_hit[g])
        );
    end

    // Walk downwards so the lowest valid entry (highest priority) wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = MAX_PER_LINE - 1; k >= 0; k--)
            if (x_hit[k] && CW'(k) < cnt_q) begin
                win_valid = 1'b1;
                win_idx   = LW'(k);
            end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_y_d   = line_y_q;
        cnt_d      = cnt_q;
        list_d     = list_q;
        ready_d    = ready_q;
        on_d       = 1'b0;
        datas_d    = datas_q;
        ovf_d      = frame_start ? 1'b0 : ovf_q;
        done_cnt_d = done_cnt_q + {7'd0, count_finished};
        case (state_q)
            SCAN: begin
                idx_d = idx_q + 1'b1;
                if (y_hit) begin
                    if (cnt_q < CW'(MAX_PER_LINE)) begin
                        list_d[cnt_q[LW-1:0]] = active_q[idx_q];
                        cnt_d = cnt_q + 1'b1;
                    end else begin
`ifdef SPRITE_OVERFLOW_EN
                        ovf_d = 1'b1;
`endif
                    end
                end
                if (idx_q == AW'(NUM_SPRITES - 1)) begin
                    state_d = DRAW;
                    ready_d = 1'b1;
                end
            end
            DRAW: begin
                on_d    = win_valid;
                datas_d = win_valid ? list_q[win_idx] : datas_q;
            end
            default: ;
        endcase
        if (line_start) begin
            state_d    = SCAN;
            idx_d      = '0;
            line_y_d   = pixel_y;
            cnt_d      = '0;
            ready_d    = 1'b0;
            on_d       = 1'b0;
            done_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            line_y_q   <= '0;
            cnt_q      <= '0;
            list_q     <= '{default: '0};
            shadow_q   <= '{default: '0};
            active_q   <= '{default: '0};
            on_q       <= 1'b0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            datas_q    <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            line_y_q   <= line_y_d;
            cnt_q      <= cnt_d;
            list_q     <= list_d;
            on_q       <= on_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            datas_q    <= datas_d;
            done_cnt_q <= done_cnt_d;
            if (wr_en) shadow_q[wr_addr] <= wr_data;
            if (frame_start) active_q <= shadow_q;
        end
    end

    assign unused_done  = ^done_cnt_q;
    assign sprite_on    = on_q;
    assign sprite_datas = datas_q;
    assign line_ready   = ready_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: directed stimulus with a line-level reference model checked every cycle, plus literal spot checks.
module tb_sprite_scheduler;
    logic        clk_pixel = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [8:0]  pixel_y = '0;
    logic        line_start = 1'b0, frame_start = 1'b0, wr_en = 1'b0, count_finished = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        sprite_on, line_ready, overflow;
    logic [31:0] sprite_datas;

    int checks = 0;
    int failures = 0;

    sprite_scheduler dut (
        .clk_pixel(clk_pixel), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .count_finished(count_finished), .sprite_on(sprite_on),
        .sprite_datas(sprite_datas), .line_ready(line_ready), .overflow(overflow)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] desc(input int en, input int x, input int y, input int off);
        logic [31:0] w;
        w = {3'b000, en[0], x[9:0], y[8:0], off[8:0]};
        return w;
    endfunction

    // Reference model: the line list is built at once from the scan rules; outputs follow the cycle timing.
    logic [31:0] shadow_m [8];
    logic [31:0] active_m [8];
    logic [31:0] lw [4];
    int          lcnt = 0, phase = -1, ovf_slot = -1;
    logic        e_on = 0, e_ready = 0, e_ovf = 0;
    logic [31:0] e_datas = '0;

    initial forever begin
        @(posedge clk_pixel);
        if (!reset) begin
            for (int s = 0; s < 8; s++) begin shadow_m[s] = '0; active_m[s] = '0; end
            lcnt = 0; phase = -1; ovf_slot = -1;
            e_on = 0; e_ready = 0; e_ovf = 0; e_datas = '0;
        end else begin
            if (frame_start) e_ovf = 0;
            if (line_start) begin
                lcnt = 0; ovf_slot = -1;
                for (int s = 0; s < 8; s++) begin
                    int y;
                    y = int'(active_m[s][17:9]);
                    if (active_m[s][28] && y <= int'(pixel_y) && int'(pixel_y) <= y + 19) begin
                        if (lcnt < 4) begin lw[lcnt] = active_m[s]; lcnt++; end
                        else if (ovf_slot < 0) ovf_slot = s;
                    end
                end
                phase = 0; e_ready = 0; e_on = 0;
            end else if (phase >= 0 && phase < 8) begin
`ifdef SPRITE_OVERFLOW_EN
                if (phase == ovf_slot) e_ovf = 1;
`endif
                phase++;
                if (phase == 8) e_ready = 1;
                e_on = 0;
            end else if (phase == 8) begin
                e_on = 0;
                for (int k = 0; k < lcnt; k++) begin
                    int x;
                    x = int'(lw[k][27:18]);
                    if (x <= int'(pixel_x) && int'(pixel_x) <= x + 19) begin
                        e_on = 1; e_datas = lw[k];
                        break;
                    end
                end
            end
            if (frame_start) for (int s = 0; s < 8; s++) active_m[s] = shadow_m[s];
            if (wr_en) shadow_m[wr_addr] = wr_data;
        end
    end

    initial forever begin
        @(posedge clk_pixel);
        #1;
        if (reset) begin
            chk("model_sprite_on", {31'd0, sprite_on}, {31'd0, e_on});
            chk("model_sprite_datas", sprite_datas, e_datas);
            chk("model_line_ready", {31'd0, line_ready}, {31'd0, e_ready});
            chk("model_overflow", {31'd0, overflow}, {31'd0, e_ovf});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_pixel);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1; wr_addr = a[2:0]; wr_data = d;
        @(negedge clk_pixel);
        wr_en = 0;
    endtask

    task automatic frame();
        frame_start = 1;
        @(negedge clk_pixel);
        frame_start = 0;
    endtask

    task automatic line(input int y);
        pixel_y = y[8:0]; line_start = 1;
        @(negedge clk_pixel);
        line_start = 0;
    endtask

    task automatic px(input int x);
        pixel_x = x[9:0];
        @(negedge clk_pixel);
    endtask

    initial begin
`ifdef SPRITE_OVERFLOW_EN
        logic ovf_exp = 1'b1;
`else
        logic ovf_exp = 1'b0;
`endif
        step(3);
        chk("reset_sprite_on", {31'd0, sprite_on}, 32'd0);
        chk("reset_sprite_datas", sprite_datas, 32'd0);
        chk("reset_line_ready", {31'd0, line_ready}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1;
        step(1);

        // single sprite at (32,32)
        wr(0, desc(1, 32, 32, 8));
        frame();
        line(32);
        step(7);
        chk("ready_low_before", {31'd0, line_ready}, 32'd0);
        step(1);
        chk("ready_high_9", {31'd0, line_ready}, 32'd1);
        px(31); chk("px31_off", {31'd0, sprite_on}, 32'd0);
        px(32); chk("px32_on", {31'd0, sprite_on}, 32'd1);
        chk("px32_datas", sprite_datas, 32'h1080_4008);
        for (int x = 33; x <= 51; x++) px(x);
        chk("px51_on", {31'd0, sprite_on}, 32'd1);
        px(52); chk("px52_off", {31'd0, sprite_on}, 32'd0);
        chk("px52_hold", sprite_datas, 32'h1080_4008);

        // priority between overlapping slots
        wr(0, 32'd0);
        wr(3, desc(1, 40, 32, 3));
        wr(1, desc(1, 45, 32, 1));
        frame();
        line(32);
        step(8);
        px(42); chk("prio_slot3", sprite_datas, 32'h10A0_4003);
        px(50); chk("prio_slot1", sprite_datas, 32'h10B4_4001);
        px(60); chk("prio_slot1_tail", sprite_datas, 32'h10B4_4001);
        px(65); chk("prio_px65_off", {31'd0, sprite_on}, 32'd0);
        for (int x = 36; x <= 68; x++) px(x);

        // five sprites on one line
        wr(3, 32'd0);
        for (int s = 0; s < 4; s++) wr(s, desc(1, 200 + 10 * s, 100, s));
        wr(4, desc(1, 300, 100, 4));
        frame();
        line(100);
        step(8);
        chk("ovf_flag", {31'd0, overflow}, {31'd0, ovf_exp});
        px(205); chk("ovf_slot0", sprite_datas, desc(1, 200, 100, 0));
        px(305); chk("ovf_slot4_dropped", {31'd0, sprite_on}, 32'd0);
        for (int x = 195; x <= 255; x += 3) px(x);
        frame();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // mid-frame write waits for frame_start
        wr(0, desc(1, 32, 32, 8));
        for (int s = 1; s < 5; s++) wr(s, 32'd0);
        frame();
        line(32); step(8);
        px(40); chk("old_pos_on", {31'd0, sprite_on}, 32'd1);
        wr(0, desc(1, 100, 32, 8));
        line(32); step(8);
        px(40); chk("pre_commit_on", {31'd0, sprite_on}, 32'd1);
        px(110); chk("pre_commit_new_off", {31'd0, sprite_on}, 32'd0);
        frame();
        line(32); step(8);
        px(110); chk("post_commit_on", {31'd0, sprite_on}, 32'd1);
        px(40); chk("post_commit_old_off", {31'd0, sprite_on}, 32'd0);

        // restart mid-scan
        line(32); step(3);
        line(32);
        step(7); chk("restart_ready_low", {31'd0, line_ready}, 32'd0);
        step(1); chk("restart_ready_high", {31'd0, line_ready}, 32'd1);
        for (int x = 98; x <= 122; x++) px(x);

        // no 9-bit wrap on y
        wr(0, desc(1, 10, 500, 5));
        frame();
        line(505); step(8);
        px(15); chk("y505_hit", {31'd0, sprite_on}, 32'd1);
        line(10); step(8);
        px(15); chk("y10_miss", {31'd0, sprite_on}, 32'd0);
        line(511); step(8);
        px(29); chk("y511_x29_on", {31'd0, sprite_on}, 32'd1);
        px(30); chk("y511_x30_off", {31'd0, sprite_on}, 32'd0);
        line(499); step(8);
        px(15); chk("y499_miss", {31'd0, sprite_on}, 32'd0);

        // async reset mid-draw
        line(505); step(8);
        px(15); chk("pre_reset_on", {31'd0, sprite_on}, 32'd1);
        reset = 0;
        #1;
        chk("mid_reset_on", {31'd0, sprite_on}, 32'd0);
        chk("mid_reset_datas", sprite_datas, 32'd0);
        chk("mid_reset_ready", {31'd0, line_ready}, 32'd0);
        chk("mid_reset_ovf", {31'd0, overflow}, 32'd0);
        step(2);
        reset = 1;
        step(1);
        line(505); step(8);
        chk("after_reset_ready", {31'd0, line_ready}, 32'd1);
        px(15); chk("after_reset_off", {31'd0, sprite_on}, 32'd0);
        frame();
        line(505); step(8);
        px(15); chk("after_reset_frame_off", {31'd0, sprite_on}, 32'd0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
